wb_writeback_unit: RTL and testbench
====================================

// Module: wb_writeback_unit
// PURPOSE
//  Writeback stage of the 5-stage 16-bit pipeline: the writer side of the register-file write port read by decode.
//  Holds the MEM/WB pipeline register, waits for variable-latency load data, selects the write value,
//  and drives writeReg_WB/dstReg_WB/regDataToWrite. Also tracks halt and counts retired instructions.
// PARAMETERS
//  DATA_W    16  datapath width
//  REG_AW    4   register-address width
//  RETIRE_W  16  retired-instruction counter width
// PORTS
//  clk             in   1         clock, all state updates on rising edge
//  rst             in   1         asynchronous, active-high reset
//  valid_MEM       in   1         MEM stage presents a real instruction (0 = bubble)
//  writeReg_MEM    in   1         instruction writes a register
//  dstReg_MEM      in   REG_AW    destination register
//  memRead_MEM     in   1         instruction is a load (result comes from memData)
//  isPCS_MEM       in   1         instruction writes PC_plus4_MEM (PCS)
//  aluResult_MEM   in   DATA_W    ALU/LLB/LHB result
//  PC_plus4_MEM    in   DATA_W    return address for PCS
//  halt_MEM        in   1         instruction is HLT
//  flush_WB        in   1         discard incoming and pending instruction
//  memData         in   DATA_W    load data from data memory
//  memDataValid    in   1         memData valid this cycle
//  stall_WB        out  1         upstream must hold MEM stage (combinational)
//  writeReg_WB     out  1         register-file write enable (registered)
//  dstReg_WB       out  REG_AW    register-file write address (registered)
//  regDataToWrite  out  DATA_W    register-file write data (registered)
//  halt_WB         out  1         sticky: HLT has retired
//  retired         out  RETIRE_W  retired-instruction count
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pipeline register empty; async assert, sync-safe deassert.
//  States: IDLE (no pending load), WAIT_LOAD (load captured, data not yet returned), HALTED.
//  Capture: at edge when valid_MEM & ~stall_WB & ~flush_WB & state!=HALTED.
//  Non-load capture (IDLE->IDLE): writeReg_WB/dstReg_WB/regDataToWrite valid for exactly the next cycle.
//   Data select: isPCS_MEM ? PC_plus4_MEM : aluResult_MEM. Latency: 1 cycle MEM->WB outputs.
//  Load capture -> WAIT_LOAD; memDataValid in same cycle as capture is ignored (data arrives >=1 cycle later).
//  WAIT_LOAD: stall_WB = ~memDataValid. On edge with memDataValid=1: latch memData, write asserted next
//   cycle, go IDLE; a new instruction may be captured on that same edge (back-to-back, no bubble).
//  Cycles with no capture: writeReg_WB=0 next cycle; dstReg_WB/regDataToWrite hold last value.
//  writeReg_WB forced 0 when dst is R0 or writeReg_MEM=0; such instructions still retire.
//  retired increments once per instruction at the cycle its outputs are presented (loads: after data);
//   saturates at all-ones, no wrap.
//  halt_MEM capture: retires next cycle, halt_WB=1, state HALTED; HALTED ignores valid_MEM,
//   stall_WB=0, no writes until rst.
//  flush_WB: highest priority. Blocks capture, aborts WAIT_LOAD to IDLE without write or retire,
//   late memDataValid for aborted load ignored; flush with memDataValid same cycle -> flush wins.
//  stall_WB only high in WAIT_LOAD; never high in IDLE or HALTED.
//  rst mid-WAIT_LOAD: immediate return to IDLE, outputs 0, counter 0.
// TESTING
//  ADD R3 (alu=0x1234) captured -> next cycle writeReg_WB=1, dstReg_WB=3, regDataToWrite=0x1234, retired=1.
//  LW R5, memDataValid 3 cycles later with 0xBEEF -> stall_WB=1 for 2 cycles, then write R5=0xBEEF, retired+1.
//  LW R2 then ADD R4 back-to-back, memDataValid after 1 cycle -> R2 written, R4 written next cycle, no bubble.
//  PCS R1 with PC_plus4=0x0042, and ADD to R0 -> R1=0x0042; R0 write suppressed, both retire.
//  LW pending, flush_WB with memDataValid same cycle -> no write, no retire, IDLE, stall_WB=0.
//  HLT captured, then valid ADD -> halt_WB=1 next cycle, ADD ignored; rst clears halt_WB and retired.

Source files
------------

// File: rtl/wb_writeback_unit.sv
// -----------------------------------------------------------------------------
// wb_writeback_unit
//   Writeback stage of the 5-stage 16-bit pipeline. Holds the MEM/WB pipeline
//   register, waits for variable-latency load data, selects the register-file
//   write value and drives the write port read by decode. It also tracks halt
//   and counts retired instructions.
//
//   Ports
//     clk, rst        clock and asynchronous active-high reset
//     valid_MEM       MEM stage holds a real instruction (0 = bubble)
//     writeReg_MEM    instruction writes a register
//     dstReg_MEM      destination register
//     memRead_MEM     instruction is a load
//     isPCS_MEM       instruction writes PC_plus4_MEM
//     aluResult_MEM   ALU/LLB/LHB result
//     PC_plus4_MEM    return address for PCS
//     halt_MEM        instruction is HLT
//     flush_WB        discard incoming and pending instruction
//     memData         load data from data memory
//     memDataValid    memData valid this cycle
//     stall_WB        upstream must hold MEM (combinational)
//     writeReg_WB     register-file write enable (registered)
//     dstReg_WB       register-file write address (registered)
//     regDataToWrite  register-file write data (registered)
//     halt_WB         sticky: HLT has retired
//     retired         saturating retired-instruction count
// -----------------------------------------------------------------------------
module wb_writeback_unit #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_MEM,
  input  logic                writeReg_MEM,
  input  logic [REG_AW-1:0]   dstReg_MEM,
  input  logic                memRead_MEM,
  input  logic                isPCS_MEM,
  input  logic [DATA_W-1:0]   aluResult_MEM,
  input  logic [DATA_W-1:0]   PC_plus4_MEM,
  input  logic                halt_MEM,
  input  logic                flush_WB,
  input  logic [DATA_W-1:0]   memData,
  input  logic                memDataValid,
  output logic                stall_WB,
  output logic                writeReg_WB,
  output logic [REG_AW-1:0]   dstReg_WB,
  output logic [DATA_W-1:0]   regDataToWrite,
  output logic                halt_WB,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, HALTED} state_t;

  // One instruction ready to be presented on the write port.
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
    logic              halt;
  } wbEntry_t;

  state_t            state;
  logic              pendWe;     // pending load's write enable
  logic [REG_AW-1:0] pendDst;    // pending load's destination
  wbEntry_t          held;       // instruction captured on a load-return edge
  logic              heldValid;

  wbEntry_t incoming;
  wbEntry_t pres;
  logic     presValid;
  logic     capture;
  logic     loadDone;
  logic     flushActive;
  logic     holdIncoming;

  assign stall_WB    = (state == WAIT_LOAD) & ~memDataValid;
  assign capture     = valid_MEM & ~stall_WB & ~flush_WB & (state != HALTED);
  assign loadDone    = (state == WAIT_LOAD) & memDataValid;
  // A halted core ignores flush; only rst leaves HALTED.
  assign flushActive = flush_WB & (state != HALTED);

  // When a load returns on the same edge a new instruction is captured, the
  // load owns the write port next cycle, so the newcomer waits one cycle in
  // 'held'. Every later capture in an unbroken stream shifts through 'held'.
  assign holdIncoming = capture & ~memRead_MEM & (loadDone | heldValid);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    incoming.we   = writeReg_MEM & (dstReg_MEM != '0);  // R0 is never written
    incoming.dst  = dstReg_MEM;
    incoming.data = isPCS_MEM ? PC_plus4_MEM : aluResult_MEM;
    incoming.halt = halt_MEM;

    presValid = 1'b0;
    pres      = '0;
    if (!flushActive) begin
      if (loadDone) begin
        presValid = 1'b1;
        pres      = '{we: pendWe, dst: pendDst, data: memData, halt: 1'b0};
      end else if (heldValid) begin
        presValid = 1'b1;
        pres      = held;
      end else if (capture && !memRead_MEM) begin
        presValid = 1'b1;
        pres      = incoming;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pendWe         <= 1'b0;
      pendDst        <= '0;
      held           <= '0;
      heldValid      <= 1'b0;
      writeReg_WB    <= 1'b0;
      dstReg_WB      <= '0;
      regDataToWrite <= '0;
      halt_WB        <= 1'b0;
      retired        <= '0;
    end else begin
      writeReg_WB <= presValid & pres.we;
      if (presValid) begin
        dstReg_WB      <= pres.dst;
        regDataToWrite <= pres.data;
        if (retired != '1) retired <= retired + 1'b1;
        if (pres.halt) halt_WB <= 1'b1;
      end

      heldValid <= holdIncoming;
      if (holdIncoming) held <= incoming;

      if (capture && memRead_MEM) begin
        pendWe  <= incoming.we;
        pendDst <= incoming.dst;
      end

      if (flushActive)                  state <= IDLE;
      else if (capture && halt_MEM)     state <= HALTED;
      else if (capture && memRead_MEM)  state <= WAIT_LOAD;
      else if (loadDone)                state <= IDLE;
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
module tb_wb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        valid_MEM;
  logic        writeReg_MEM;
  logic [3:0]  dstReg_MEM;
  logic        memRead_MEM;
  logic        isPCS_MEM;
  logic [15:0] aluResult_MEM;
  logic [15:0] PC_plus4_MEM;
  logic        halt_MEM;
  logic        flush_WB;
  logic [15:0] memData;
  logic        memDataValid;
  logic        stall_WB;
  logic        writeReg_WB;
  logic [3:0]  dstReg_WB;
  logic [15:0] regDataToWrite;
  logic        halt_WB;
  logic [15:0] retired;

  wb_writeback_unit dut (
    .clk(clk), .rst(rst),
    .valid_MEM(valid_MEM), .writeReg_MEM(writeReg_MEM), .dstReg_MEM(dstReg_MEM),
    .memRead_MEM(memRead_MEM), .isPCS_MEM(isPCS_MEM), .aluResult_MEM(aluResult_MEM),
    .PC_plus4_MEM(PC_plus4_MEM), .halt_MEM(halt_MEM), .flush_WB(flush_WB),
    .memData(memData), .memDataValid(memDataValid), .stall_WB(stall_WB),
    .writeReg_WB(writeReg_WB), .dstReg_WB(dstReg_WB), .regDataToWrite(regDataToWrite),
    .halt_WB(halt_WB), .retired(retired)
  );

  typedef struct {
    logic        we;
    logic [3:0]  dst;
    logic [15:0] data;
  } expWrite_t;

  expWrite_t sbQ[$];
  int checks = 0;
  int errors = 0;
  int expCount = 0;
  logic [15:0] lastRet = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    valid_MEM = 0; writeReg_MEM = 0; dstReg_MEM = 0; memRead_MEM = 0;
    isPCS_MEM = 0; aluResult_MEM = 0; PC_plus4_MEM = 0; halt_MEM = 0;
    flush_WB = 0; memData = 0; memDataValid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic we, input logic [3:0] dst, input logic load,
                       input logic pcs, input logic [15:0] alu, input logic [15:0] pc,
                       input logic halt);
    valid_MEM = 1; writeReg_MEM = we; dstReg_MEM = dst; memRead_MEM = load;
    isPCS_MEM = pcs; aluResult_MEM = alu; PC_plus4_MEM = pc; halt_MEM = halt;
  endtask

  task automatic push(input logic we, input logic [3:0] dst, input logic [15:0] data);
    expWrite_t e;
    e.we = we; e.dst = dst; e.data = data;
    sbQ.push_back(e);
  endtask

  // Scoreboard: every time the retire count moves, one expected instruction
  // must have been presented on the write port in program order.
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
      expCount = 0;
      lastRet  = '0;
    end else begin
      if (retired != lastRet) begin
        if (sbQ.size() == 0) begin
          check("sb_unexpected_retire", retired, lastRet);
        end else begin
          expWrite_t e;
          e = sbQ.pop_front();
          expCount++;
          check("sb_retired", retired, expCount);
          check("sb_we", writeReg_WB, e.we);
          if (e.we) begin
            check("sb_dst", dstReg_WB, e.dst);
            check("sb_data", regDataToWrite, e.data);
          end
        end
      end else begin
        check("sb_no_spurious_write", writeReg_WB, 1'b0);
      end
      lastRet = retired;
    end
  end

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    check("rst_we", writeReg_WB, 0);
    check("rst_dst", dstReg_WB, 0);
    check("rst_data", regDataToWrite, 0);
    check("rst_halt", halt_WB, 0);
    check("rst_retired", retired, 0);
    check("rst_stall", stall_WB, 0);
    rst = 0;
    tick();

    // ADD R3 = 0x1234
    instr(1, 3, 0, 0, 16'h1234, 16'h0, 0); push(1, 3, 16'h1234);
    tick(); idle();
    check("add_we", writeReg_WB, 1);
    check("add_dst", dstReg_WB, 3);
    check("add_data", regDataToWrite, 16'h1234);
    check("add_retired", retired, 1);
    tick();
    check("idle_we", writeReg_WB, 0);
    check("idle_dst_hold", dstReg_WB, 3);
    check("idle_data_hold", regDataToWrite, 16'h1234);

    // LW R5; same-cycle memDataValid is junk and must be ignored
    instr(1, 5, 1, 0, 16'h0, 16'h0, 0); push(1, 5, 16'hBEEF);
    memDataValid = 1; memData = 16'hDEAD;
    tick(); idle();
    check("lw_no_early_write", writeReg_WB, 0);
    for (int i = 0; i < 2; i++) begin
      #1 check("lw_stall", stall_WB, 1);
      tick();
    end
    memDataValid = 1; memData = 16'hBEEF;
    #1 check("lw_stall_release", stall_WB, 0);
    tick(); idle();
    check("lw_we", writeReg_WB, 1);
    check("lw_dst", dstReg_WB, 5);
    check("lw_data", regDataToWrite, 16'hBEEF);
    check("lw_retired", retired, 2);

    // LW R2 then ADD R4 back-to-back
    instr(1, 2, 1, 0, 16'h0, 16'h0, 0); push(1, 2, 16'h2222);
    tick(); idle();
    instr(1, 4, 0, 0, 16'h0404, 16'h0, 0); push(1, 4, 16'h0404);
    memDataValid = 1; memData = 16'h2222;
    tick(); idle();
    check("b2b_r2_dst", dstReg_WB, 2);
    check("b2b_r2_data", regDataToWrite, 16'h2222);
    tick();
    check("b2b_r4_we", writeReg_WB, 1);
    check("b2b_r4_dst", dstReg_WB, 4);
    check("b2b_r4_data", regDataToWrite, 16'h0404);
    check("b2b_retired", retired, 4);

    // PCS R1, then ADD to R0 (write suppressed, still retires)
    instr(1, 1, 0, 1, 16'h9999, 16'h0042, 0); push(1, 1, 16'h0042);
    tick();
    instr(1, 0, 0, 0, 16'h5555, 16'h0, 0); push(0, 0, 16'h0);
    check("pcs_data", regDataToWrite, 16'h0042);
    tick(); idle();
    check("r0_we", writeReg_WB, 0);
    check("r0_retired", retired, 6);

    // LW R6 aborted by flush arriving with its data
    instr(1, 6, 1, 0, 16'h0, 16'h0, 0);
    tick(); idle();
    flush_WB = 1; memDataValid = 1; memData = 16'h6666;
    tick(); idle();
    check("flush_we", writeReg_WB, 0);
    check("flush_stall", stall_WB, 0);
    check("flush_retired", retired, 6);
    memDataValid = 1; memData = 16'h7777;
    tick(); idle();
    check("late_data_ignored", writeReg_WB, 0);
    // flush also blocks a valid capture
    instr(1, 9, 0, 0, 16'hAAAA, 16'h0, 0); flush_WB = 1;
    tick(); idle();
    check("flush_block_we", writeReg_WB, 0);
    check("flush_block_retired", retired, 6);

    // Two consecutive ADDs, one-cycle latency each
    instr(1, 7, 0, 0, 16'h0707, 16'h0, 0); push(1, 7, 16'h0707);
    tick();
    instr(1, 8, 0, 0, 16'h0808, 16'h0, 0); push(1, 8, 16'h0808);
    check("stream_r7", dstReg_WB, 7);
    tick(); idle();
    check("stream_r8", dstReg_WB, 8);
    check("stream_retired", retired, 8);

    // HLT, then a valid ADD is ignored
    instr(0, 0, 0, 0, 16'h0, 16'h0, 1); push(0, 0, 16'h0);
    tick();
    instr(1, 9, 0, 0, 16'h0909, 16'h0, 0);
    check("hlt_halt", halt_WB, 1);
    check("hlt_retired", retired, 9);
    #1 check("hlt_stall", stall_WB, 0);
    tick(); idle();
    check("halted_no_write", writeReg_WB, 0);
    check("halted_retired", retired, 9);
    rst = 1;
    #1;
    check("rst_clr_halt", halt_WB, 0);
    check("rst_clr_retired", retired, 0);
    tick();
    rst = 0;
    tick();

    // rst in the middle of WAIT_LOAD
    instr(1, 3, 1, 0, 16'h0, 16'h0, 0); push(1, 3, 16'h3333);
    tick(); idle();
    check("mid_wait_stall", stall_WB, 1);
    rst = 1;
    #1;
    check("mid_rst_stall", stall_WB, 0);
    check("mid_rst_retired", retired, 0);
    tick();
    rst = 0;
    instr(1, 10, 0, 0, 16'h0A0A, 16'h0, 0); push(1, 10, 16'h0A0A);
    tick(); idle();
    check("post_rst_dst", dstReg_WB, 10);
    check("post_rst_retired", retired, 1);
    memDataValid = 1; memData = 16'h3333;
    tick(); idle();
    check("post_rst_no_stale_load", writeReg_WB, 0);
    tick();

    check("sb_empty", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
